key_ctrl: RTL and testbench
===========================

KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately on reset assertion, independent of clk_sys.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL be the stable-level time in clk_sys cycles required to accept a key press or release (20 ms at 50 MHz).
REQ-003 Parameter CLR_HOLD, default 50000000, SHALL be the minimum assertion time of clr_cnt in clk_sys cycles, so it spans at least one full clk_1s period of the downstream 0-99 counter.
REQ-004 Port clk_sys, input, 1 bit: 50 MHz system clock; all flops SHALL be rising-edge.
REQ-005 Port clr, input, 1 bit: asynchronous active-high reset.
REQ-006 Port key_pause_n, input, 1 bit: raw, asynchronous, bouncing push-button, active-low.
REQ-007 Port key_clr_n, input, 1 bit: raw, asynchronous, bouncing push-button, active-low.
REQ-008 Port pause, output, 1 bit: registered level that toggles once per accepted pause-key press; it drives the counter's pause input.
REQ-009 Port clr_cnt, output, 1 bit: registered, stretched clear request; it drives the counter's clear input.
REQ-010 Port key_busy, output, 1 bit: high while either key FSM is in any state other than IDLE.

Function
REQ-011 Each raw key SHALL pass through its own 2-flop synchronizer before any other logic; synchronized levels SHALL be called kp and kc.
REQ-012 Each key SHALL have an independent 4-state FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 Each FSM SHALL own a debounce counter of ceil(log2(DEBOUNCE_CYCLES)) bits that is zeroed on every state change.
REQ-014 In IDLE, synchronized level 0 SHALL move the FSM to PRESS_WAIT on the next edge.
REQ-015 In PRESS_WAIT, level 0 SHALL increment the counter.
REQ-016 In PRESS_WAIT, level 1 SHALL return the FSM to IDLE (bounce rejected).
REQ-017 In PRESS_WAIT, when the counter equals DEBOUNCE_CYCLES-1 and the level is still 0, the FSM SHALL enter PRESSED on that edge, and that edge is the "accept" event.
REQ-018 In PRESSED, level 1 SHALL move the FSM to RELEASE_WAIT.
REQ-019 In RELEASE_WAIT, level 1 SHALL increment the counter, and at DEBOUNCE_CYCLES-1 the FSM SHALL go to IDLE.
REQ-020 In RELEASE_WAIT, level 0 SHALL return the FSM to PRESSED with no new accept event.
REQ-021 On the pause-key accept edge, pause SHALL invert; holding the key SHALL NOT toggle it again.
REQ-022 On the clr-key accept edge, clr_cnt SHALL go 1 and a stretch counter of ceil(log2(CLR_HOLD)) bits SHALL load 0.
REQ-023 clr_cnt SHALL stay 1 until both conditions hold: the stretch counter has reached CLR_HOLD-1 and the clr FSM is IDLE or RELEASE_WAIT; it SHALL drop on the next edge.
REQ-024 The stretch counter SHALL saturate at CLR_HOLD-1 and SHALL NOT wrap.
REQ-025 A new clr accept edge while clr_cnt=1 SHALL reload the stretch counter to 0.
REQ-026 Latency from the first edge that samples a stable raw 0 to the pause toggle or clr_cnt rise SHALL be exactly DEBOUNCE_CYCLES+3 cycles (2 synchronizer, 1 IDLE exit, DEBOUNCE_CYCLES in PRESS_WAIT).
REQ-027 Simultaneous presses SHALL be handled independently; pause and clr_cnt may change on the same edge.
REQ-028 clr_cnt SHALL NOT modify pause.

Reset
REQ-029 On clr=1, outputs SHALL be pause=0, clr_cnt=0 and key_busy=0.
REQ-030 On clr=1, both FSMs SHALL be IDLE, all counters 0, and synchronizer flops 1 (released-key level).
REQ-031 Reset asserted mid-press or mid-stretch SHALL abort the operation; after release, a key still held SHALL be re-debounced from IDLE.

Verification (DEBOUNCE_CYCLES=4, CLR_HOLD=10)
REQ-032 Clean press: key_pause_n held 0 for 20 cycles -> pause goes 0->1 exactly 7 cycles after the first 0 sample and stays 1; key_busy=1 from cycle 3.
REQ-033 Bounce: key_pause_n toggles 0,1,0,1 every 2 cycles, then stays 1 -> pause stays 0 and the FSM returns to IDLE.
REQ-034 Short clr tap: key_clr_n held 0 for 8 cycles -> clr_cnt=1 from cycle 7 for 10 cycles, then 0.
REQ-035 Long clr hold: key_clr_n held 0 for 40 cycles -> clr_cnt stays 1 until RELEASE_WAIT is entered after release, then drops on the next edge.
REQ-036 Two pause presses separated by a release of 10 cycles -> pause sequence 0->1->0, one toggle per press.
REQ-037 Reset mid-stretch: clr pulsed at stretch count 5 -> clr_cnt=0 immediately (asynchronous); a subsequent 10-cycle press re-asserts clr_cnt after 7 cycles.

Source files
------------

// File: rtl/key_ctrl.sv
// rtl/key_ctrl.sv - debounced pause/clear push-button controller for the 0-99 counter
module key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CLR_HOLD        = 50000000
) (
  input  logic clk_sys,
  input  logic clr,
  input  logic key_pause_n,
  input  logic key_clr_n,
  output logic pause,
  output logic clr_cnt,
  output logic key_busy
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam int K_PAUSE = 0;
  localparam int K_CLR   = 1;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] HOLD_LAST = SW'(CLR_HOLD - 1);

  logic [1:0] sync_meta;
  logic [1:0] sync_q;
  logic       kp;
  logic       kc;
  logic [1:0] key;

  logic [1:0][1:0]    state;
  logic [1:0][1:0]    state_nxt;
  logic [1:0][DW-1:0] cnt;
  logic [1:0][DW-1:0] cnt_nxt;
  logic [1:0]         accept;
  logic [SW-1:0]      stretch;

  // Synchronizers reset to the released (high) level so a held key is re-debounced
  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      sync_meta <= 2'b11;
      sync_q    <= 2'b11;
    end else begin
      sync_meta <= {key_clr_n, key_pause_n};
      sync_q    <= sync_meta;
    end
  end

  assign kp  = sync_q[K_PAUSE];
  assign kc  = sync_q[K_CLR];
  assign key = {kc, kp};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    accept    = '0;
    for (int i = 0; i < 2; i++) begin
      case (state[i])
        S_IDLE: begin
          if (!key[i]) state_nxt[i] = S_PRESS_WAIT;
        end
        S_PRESS_WAIT: begin
          if (key[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (cnt[i] == DB_LAST) begin
            state_nxt[i] = S_PRESSED;
            accept[i]    = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
        S_PRESSED: begin
          if (key[i]) state_nxt[i] = S_RELEASE_WAIT;
        end
        default: begin
          if (!key[i]) begin
            state_nxt[i] = S_PRESSED;
          end else if (cnt[i] == DB_LAST) begin
            state_nxt[i] = S_IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      state <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // clr_cnt is held until the stretch saturates and the key is no longer held down
  always_ff @(posedge clk_sys or posedge clr) begin
    if (clr) begin
      pause   <= 1'b0;
      clr_cnt <= 1'b0;
      stretch <= '0;
    end else begin
      if (accept[K_PAUSE]) pause <= ~pause;
      if (accept[K_CLR]) begin
        clr_cnt <= 1'b1;
        stretch <= '0;
      end else if (clr_cnt) begin
        if (stretch != HOLD_LAST) begin
          stretch <= stretch + 1'b1;
        end else if (state[K_CLR] == S_IDLE || state[K_CLR] == S_RELEASE_WAIT) begin
          clr_cnt <= 1'b0;
        end
      end
    end
  end

  assign key_busy = (state[K_PAUSE] != S_IDLE) || (state[K_CLR] != S_IDLE);

endmodule

// File: tb/tb_key_ctrl.sv
// tb/tb_key_ctrl.sv - self-checking bench for key_ctrl with short debounce and hold
module tb_key_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int RUN  = 60;

  logic clk_sys     = 1'b0;
  logic clr         = 1'b1;
  logic key_pause_n = 1'b1;
  logic key_clr_n   = 1'b1;
  logic pause;
  logic clr_cnt;
  logic key_busy;

  key_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CLR_HOLD       (HOLD)
  ) dut (
    .clk_sys    (clk_sys),
    .clr        (clr),
    .key_pause_n(key_pause_n),
    .key_clr_n  (key_clr_n),
    .pause      (pause),
    .clr_cnt    (clr_cnt),
    .key_busy   (key_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Low-time in cycles per key and the cycle (1 = first edge sampling the press) of each output edge; 0 = none
  typedef struct {
    int p_low;
    int c_low;
    int p_rise;
    int c_rise;
    int c_fall;
  } vec_t;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } ev_t;

  vec_t       vecs[7];
  ev_t        sb[$];
  int         n_pass     = 0;
  int         n_total    = 0;
  int         cyc        = 0;
  logic       prev_pause = 1'b0;
  logic       prev_clr   = 1'b0;
  logic [0:5] bounce_pat;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic expect_ev(input int c, input int s, input int v);
    ev_t e;
    int  idx;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    idx   = 0;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].cyc * 2 + sb[i].sig <= c * 2 + s) idx = i + 1;
    sb.insert(idx, e);
  endtask

  task automatic sb_observe(input int s, input int v);
    ev_t e;
    if (sb.size() == 0) begin
      chk($sformatf("unexpected_edge_sig%0d_val%0d_at_cycle", s, v), cyc, -1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("event_sig%0d_val%0d_cycle%0d (cycle*4+sig*2+val)", e.sig, e.val, e.cyc),
          cyc * 4 + s * 2 + v, e.cyc * 4 + e.sig * 2 + e.val);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (pause !== prev_pause) begin
      sb_observe(0, int'(pause));
      prev_pause = pause;
    end
    if (clr_cnt !== prev_clr) begin
      sb_observe(1, int'(clr_cnt));
      prev_clr = clr_cnt;
    end
  endtask

  task automatic do_reset(input bit hold_keys);
    clr = 1'b1;
    if (!hold_keys) begin
      key_pause_n = 1'b1;
      key_clr_n   = 1'b1;
    end
    #1;
    chk("reset_pause", int'(pause), 0);
    chk("reset_clr_cnt", int'(clr_cnt), 0);
    chk("reset_key_busy", int'(key_busy), 0);
    repeat (2) @(posedge clk_sys);
    #1;
    clr        = 1'b0;
    cyc        = 0;
    prev_pause = 1'b0;
    prev_clr   = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input int exp_pause);
    chk({tag, "_final_pause"}, int'(pause), exp_pause);
    chk({tag, "_final_clr_cnt"}, int'(clr_cnt), 0);
    chk({tag, "_final_busy"}, int'(key_busy), 0);
    chk({tag, "_missing_events"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    do_reset(1'b0);
    if (v.p_rise != 0) expect_ev(v.p_rise, 0, 1);
    if (v.c_rise != 0) expect_ev(v.c_rise, 1, 1);
    if (v.c_fall != 0) expect_ev(v.c_fall, 1, 0);
    key_pause_n = (v.p_low > 0) ? 1'b0 : 1'b1;
    key_clr_n   = (v.c_low > 0) ? 1'b0 : 1'b1;
    for (int c = 1; c <= RUN; c++) begin
      step();
      key_pause_n = (c < v.p_low) ? 1'b0 : 1'b1;
      key_clr_n   = (c < v.c_low) ? 1'b0 : 1'b1;
      if (c == 2) chk($sformatf("v%0d_busy_c2", idx), int'(key_busy), 0);
      if (c == 3) chk($sformatf("v%0d_busy_c3", idx), int'(key_busy), 1);
    end
    finish_checks($sformatf("v%0d", idx), (v.p_rise != 0) ? 1 : 0);
  endtask

  initial begin
    // Accept lands DEB+3 = 7 cycles in and needs 5 low samples; clr falls at max(17, low+4)
    vecs[0] = '{p_low: 20, c_low: 0,  p_rise: 7, c_rise: 0, c_fall: 0};
    vecs[1] = '{p_low: 4,  c_low: 0,  p_rise: 0, c_rise: 0, c_fall: 0};
    vecs[2] = '{p_low: 5,  c_low: 0,  p_rise: 7, c_rise: 0, c_fall: 0};
    vecs[3] = '{p_low: 0,  c_low: 8,  p_rise: 0, c_rise: 7, c_fall: 17};
    vecs[4] = '{p_low: 0,  c_low: 40, p_rise: 0, c_rise: 7, c_fall: 44};
    vecs[5] = '{p_low: 20, c_low: 6,  p_rise: 7, c_rise: 7, c_fall: 17};
    vecs[6] = '{p_low: 0,  c_low: 4,  p_rise: 0, c_rise: 0, c_fall: 0};

    for (int i = 0; i < 7; i++) run_vec(i);

    // Bounce: 0,0,1,1,0,0 then released; never five consecutive low samples
    do_reset(1'b0);
    bounce_pat  = 6'b001100;
    key_pause_n = bounce_pat[0];
    for (int c = 1; c <= 20; c++) begin
      step();
      key_pause_n = (c < 6) ? bounce_pat[c] : 1'b1;
      if (c == 3) chk("bounce_busy_c3", int'(key_busy), 1);
    end
    finish_checks("bounce", 0);

    // Two pause presses of 8 cycles separated by a 10-cycle release
    do_reset(1'b0);
    expect_ev(7, 0, 1);
    expect_ev(25, 0, 0);
    key_pause_n = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      step();
      key_pause_n = (c < 8 || (c >= 18 && c < 26)) ? 1'b0 : 1'b1;
      if (c == 20) chk("two_press_pause_mid", int'(pause), 1);
    end
    finish_checks("two_press", 0);

    // Reset at stretch count 5, then a fresh 10-cycle clr press
    do_reset(1'b0);
    expect_ev(7, 1, 1);
    key_clr_n = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      key_clr_n = (c < 10) ? 1'b0 : 1'b1;
    end
    chk("mid_stretch_clr_cnt_before_reset", int'(clr_cnt), 1);
    chk("mid_stretch_pending", sb.size(), 0);
    do_reset(1'b0);
    expect_ev(7, 1, 1);
    expect_ev(17, 1, 0);
    key_clr_n = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      step();
      key_clr_n = (c < 10) ? 1'b0 : 1'b1;
    end
    finish_checks("after_mid_stretch", 0);

    // Reset mid-debounce with the key still held: re-debounced from IDLE after release
    do_reset(1'b0);
    key_clr_n = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    chk("held_busy_before_reset", int'(key_busy), 1);
    do_reset(1'b1);
    expect_ev(7, 1, 1);
    expect_ev(17, 1, 0);
    for (int c = 1; c <= 30; c++) begin
      step();
      key_clr_n = (c < 10) ? 1'b0 : 1'b1;
      if (c == 6) chk("held_clr_cnt_c6", int'(clr_cnt), 0);
    end
    finish_checks("held_through_reset", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
